// File: rtl/drvr_fifo_bank.sv
// Bank of per-terminal FIFO pairs between the driver/monitor and the bus DUT.
// Input FIFOs are first-word-fall-through toward the DUT; output FIFOs capture DUT pushes.

module drvr_fifo #(
  parameter int W        = 16,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = 0,
  parameter int CW       = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head_data,
  output logic          ovf,
  output logic          udf
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic          empty, full, do_rd, do_wr, adv_head;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd && !empty;
  assign ovf   = wr && full && !do_rd;
  assign udf   = rd && empty;
  assign do_wr = wr && (!ovf || OVF_MODE == 1);
  // Overwrite-oldest advances head on a full write just like a read would.
  assign adv_head  = do_rd || (do_wr && ovf);
  assign head_data = empty ? '0 : mem[head];

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (adv_head) head <= inc(head);
      if (do_wr)    tail <= inc(tail);
      if (do_wr && !adv_head)      count <= count + CW'(1);
      else if (adv_head && !do_wr) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= wdata;
  end
endmodule

module drvr_lane #(
  parameter int W        = 16,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = 0,
  parameter int CW       = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic          pndng,
  output logic [W-1:0]  d_pop,
  input  logic          push,
  input  logic [W-1:0]  d_push,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] in_count,
  output logic [CW-1:0] out_count,
  output logic [7:0]    ovf_cnt,
  output logic          udf_err
);
  logic         in_ovf, in_udf, out_ovf, out_udf;
  logic [W-1:0] out_head;
  logic [8:0]   ovf_sum;

  drvr_fifo #(.W(W), .DEPTH(DEPTH), .OVF_MODE(OVF_MODE), .CW(CW)) u_in (
    .clk(clk), .reset(reset), .wr(wr_en), .wdata(wr_data), .rd(pop),
    .count(in_count), .head_data(d_pop), .ovf(in_ovf), .udf(in_udf));

  drvr_fifo #(.W(W), .DEPTH(DEPTH), .OVF_MODE(OVF_MODE), .CW(CW)) u_out (
    .clk(clk), .reset(reset), .wr(push), .wdata(d_push), .rd(rd_en),
    .count(out_count), .head_data(out_head), .ovf(out_ovf), .udf(out_udf));

  assign pndng   = (in_count != '0);
  assign ovf_sum = {1'b0, ovf_cnt} + {8'd0, in_ovf} + {8'd0, out_ovf};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt  <= '0;
      udf_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      ovf_cnt  <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
      if (in_udf || out_udf) udf_err <= 1'b1;
      rd_valid <= rd_en && (out_count != '0);
      if (rd_en && (out_count != '0)) rd_data <= out_head;
    end
  end
endmodule

module drvr_fifo_bank #(
  parameter int drvrs    = 4,
  parameter int pckg_sz  = 16,
  parameter int depth    = 8,
  parameter int ovf_mode = 0,
  localparam int CW      = $clog2(depth+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         wr_en,
  input  logic [drvrs*pckg_sz-1:0] wr_data,
  input  logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         pndng,
  output logic [drvrs*pckg_sz-1:0] D_pop,
  input  logic [drvrs-1:0]         push,
  input  logic [drvrs*pckg_sz-1:0] D_push,
  input  logic [drvrs-1:0]         rd_en,
  output logic [drvrs*pckg_sz-1:0] rd_data,
  output logic [drvrs-1:0]         rd_valid,
  output logic [drvrs*CW-1:0]      in_count,
  output logic [drvrs*CW-1:0]      out_count,
  output logic [drvrs*8-1:0]       ovf_cnt,
  output logic [drvrs-1:0]         udf_err
);
  for (genvar g = 0; g < drvrs; g++) begin : g_lane
    drvr_lane #(.W(pckg_sz), .DEPTH(depth), .OVF_MODE(ovf_mode), .CW(CW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[g]),
      .wr_data  (wr_data[g*pckg_sz +: pckg_sz]),
      .pop      (pop[g]),
      .pndng    (pndng[g]),
      .d_pop    (D_pop[g*pckg_sz +: pckg_sz]),
      .push     (push[g]),
      .d_push   (D_push[g*pckg_sz +: pckg_sz]),
      .rd_en    (rd_en[g]),
      .rd_data  (rd_data[g*pckg_sz +: pckg_sz]),
      .rd_valid (rd_valid[g]),
      .in_count (in_count[g*CW +: CW]),
      .out_count(out_count[g*CW +: CW]),
      .ovf_cnt  (ovf_cnt[g*8 +: 8]),
      .udf_err  (udf_err[g])
    );
  end
endmodule

// File: tb/tb_drvr_fifo_bank.sv
// Random + directed bench: two banks (drop / overwrite policy) share stimulus and
// are compared every cycle against queue-based models.
module tb_drvr_fifo_bank;
  localparam int D = 4, W = 16, DEP = 8, CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [D-1:0]   wr_en, pop, push, rd_en;
  logic [D*W-1:0] wr_data, D_push;

  logic [D-1:0]    pndng_o [2];
  logic [D-1:0]    rd_valid_o [2];
  logic [D-1:0]    udf_o [2];
  logic [D*W-1:0]  D_pop_o [2];
  logic [D*W-1:0]  rd_data_o [2];
  logic [D*CW-1:0] in_cnt_o [2];
  logic [D*CW-1:0] out_cnt_o [2];
  logic [D*8-1:0]  ovf_o [2];

  always #5 clk = ~clk;

  drvr_fifo_bank #(.drvrs(D), .pckg_sz(W), .depth(DEP), .ovf_mode(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .pop(pop),
    .pndng(pndng_o[0]), .D_pop(D_pop_o[0]), .push(push), .D_push(D_push),
    .rd_en(rd_en), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
    .in_count(in_cnt_o[0]), .out_count(out_cnt_o[0]), .ovf_cnt(ovf_o[0]),
    .udf_err(udf_o[0]));

  drvr_fifo_bank #(.drvrs(D), .pckg_sz(W), .depth(DEP), .ovf_mode(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .pop(pop),
    .pndng(pndng_o[1]), .D_pop(D_pop_o[1]), .push(push), .D_push(D_push),
    .rd_en(rd_en), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
    .in_count(in_cnt_o[1]), .out_count(out_cnt_o[1]), .ovf_cnt(ovf_o[1]),
    .udf_err(udf_o[1]));

  // model state, index k = mode*D + channel
  logic [W-1:0] iq [2*D][$];
  logic [W-1:0] oq [2*D][$];
  logic [W-1:0] exp_rd [2*D];
  bit           exp_rv [2*D];
  bit           exp_udf [2*D];
  int           exp_ovf [2*D];

  int passed = 0, total = 0;

  task automatic chk(input string name, input int m, input int i,
                     input longint act, input longint exp);
    total++;
    if (act != exp)
      $display("FAIL %s mode%0d ch%0d got %0h expected %0h @%0t", name, m, i, act, exp, $time);
    else
      passed++;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2*D; k++) begin
      iq[k].delete(); oq[k].delete();
      exp_rd[k] = '0; exp_rv[k] = 0; exp_udf[k] = 0; exp_ovf[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < D; i++) begin
        int k, inc;
        k = m*D + i; inc = 0;
        if (pop[i]) begin
          if (iq[k].size() == 0) exp_udf[k] = 1;
          else void'(iq[k].pop_front());
        end
        if (wr_en[i]) begin
          if (iq[k].size() < DEP) iq[k].push_back(wr_data[i*W +: W]);
          else begin
            inc++;
            if (m == 1) begin void'(iq[k].pop_front()); iq[k].push_back(wr_data[i*W +: W]); end
          end
        end
        exp_rv[k] = 0;
        if (rd_en[i]) begin
          if (oq[k].size() == 0) exp_udf[k] = 1;
          else begin exp_rd[k] = oq[k].pop_front(); exp_rv[k] = 1; end
        end
        if (push[i]) begin
          if (oq[k].size() < DEP) oq[k].push_back(D_push[i*W +: W]);
          else begin
            inc++;
            if (m == 1) begin void'(oq[k].pop_front()); oq[k].push_back(D_push[i*W +: W]); end
          end
        end
        exp_ovf[k] = (exp_ovf[k] + inc > 255) ? 255 : exp_ovf[k] + inc;
      end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < D; i++) begin
        int k;
        k = m*D + i;
        chk("pndng",     m, i, pndng_o[m][i], iq[k].size() != 0);
        chk("D_pop",     m, i, D_pop_o[m][i*W +: W], (iq[k].size() != 0) ? iq[k][0] : 0);
        chk("in_count",  m, i, in_cnt_o[m][i*CW +: CW], iq[k].size());
        chk("out_count", m, i, out_cnt_o[m][i*CW +: CW], oq[k].size());
        chk("rd_valid",  m, i, rd_valid_o[m][i], exp_rv[k]);
        chk("rd_data",   m, i, rd_data_o[m][i*W +: W], exp_rd[k]);
        chk("ovf_cnt",   m, i, ovf_o[m][i*8 +: 8], exp_ovf[k]);
        chk("udf_err",   m, i, udf_o[m][i], exp_udf[k]);
      end
  endtask

  task automatic idle();
    wr_en = '0; pop = '0; push = '0; rd_en = '0;
  endtask

  // one clock: inputs already driven after a negedge
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1 compare_all();
    @(negedge clk);
    idle();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_clear();
    for (int m = 0; m < 2; m++) begin
      chk("rst_in_count0", m, 0, in_cnt_o[m][CW-1:0], 0);
      chk("rst_pndng",     m, 0, pndng_o[m], 0);
      chk("rst_ovf",       m, 0, ovf_o[m], 0);
      chk("rst_udf",       m, 0, udf_o[m], 0);
      chk("rst_rd_valid",  m, 0, rd_valid_o[m], 0);
    end
    compare_all();
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_ch(input int ch, input logic [W-1:0] v);
    wr_en[ch] = 1'b1; wr_data[ch*W +: W] = v;
    cyc();
  endtask

  initial begin
    int wp, pp, sp, rp;
    reset = 1'b1; idle(); wr_data = '0; D_push = '0;
    model_clear();
    #12;
    compare_all();
    reset = 1'b0;
    @(negedge clk);

    // ch0 simple FWFT
    write_ch(0, 16'h00A1); write_ch(0, 16'h00A2); write_ch(0, 16'h00A3);
    for (int m = 0; m < 2; m++) begin
      chk("t1_pndng0", m, 0, pndng_o[m][0], 1);
      chk("t1_count0", m, 0, in_cnt_o[m][0 +: CW], 3);
    end
    for (int j = 0; j < 3; j++) begin
      chk("t1_dpop", 0, 0, D_pop_o[0][0 +: W], 16'h00A1 + j);
      pop[0] = 1'b1; cyc();
    end
    chk("t1_pndng_end", 0, 0, pndng_o[0][0], 0);

    // ch2 overflow: drop vs overwrite
    for (int j = 1; j <= 9; j++) write_ch(2, 16'(j));
    for (int m = 0; m < 2; m++) begin
      chk("t2_count2", m, 2, in_cnt_o[m][2*CW +: CW], 8);
      chk("t2_ovf2",   m, 2, ovf_o[m][16 +: 8], 1);
      chk("t2_model_ovf2", m, 2, exp_ovf[m*D+2], 1);
    end
    for (int j = 0; j < 8; j++) begin
      chk("t2_drop_dpop", 0, 2, D_pop_o[0][2*W +: W], j + 1);
      chk("t3_ovwr_dpop", 1, 2, D_pop_o[1][2*W +: W], j + 2);
      pop[2] = 1'b1; cyc();
    end

    // ch1 full with simultaneous write+pop, wrapping pointers
    for (int j = 0; j < 8; j++) write_ch(1, 16'h0100 + 16'(j));
    for (int j = 0; j < 20; j++) begin
      wr_en[1] = 1'b1; pop[1] = 1'b1; wr_data[W +: W] = 16'h0200 + 16'(j); cyc();
    end
    wr_en[1] = 1'b1; pop[1] = 1'b1; wr_data[W +: W] = 16'hBEEF; cyc();
    for (int m = 0; m < 2; m++) begin
      chk("t4_count1", m, 1, in_cnt_o[m][CW +: CW], 8);
      chk("t4_ovf1",   m, 1, ovf_o[m][8 +: 8], 0);
    end
    for (int j = 0; j < 7; j++) begin pop[1] = 1'b1; cyc(); end
    chk("t4_last_beef", 0, 1, D_pop_o[0][W +: W], 16'hBEEF);
    chk("t4_last_beef", 1, 1, D_pop_o[1][W +: W], 16'hBEEF);
    pop[1] = 1'b1; cyc();

    // ch3 output FIFO, then underflow read
    push[3] = 1'b1; D_push[3*W +: W] = 16'h1234; cyc();
    rd_en[3] = 1'b1; cyc();
    chk("t5_rd_valid3", 0, 3, rd_valid_o[0][3], 1);
    chk("t5_rd_data3",  0, 3, rd_data_o[0][3*W +: W], 16'h1234);
    rd_en[3] = 1'b1; cyc();
    chk("t5_rd_valid3_empty", 0, 3, rd_valid_o[0][3], 0);
    chk("t5_udf3", 0, 3, udf_o[0][3], 1);
    chk("t5_udf3", 1, 3, udf_o[1][3], 1);

    // fill ch0 then asynchronous reset between edges
    for (int j = 0; j < 5; j++) write_ch(0, 16'h0C00 + 16'(j));
    async_reset();

    // overflow counter saturation: both FIFOs of ch0 overfilled
    for (int j = 0; j < 300; j++) begin
      wr_en[0] = 1'b1; push[0] = 1'b1;
      wr_data = {$urandom(), $urandom()}; D_push = {$urandom(), $urandom()};
      cyc();
    end
    chk("sat_ovf0", 0, 0, ovf_o[0][7:0], 255);
    chk("sat_ovf0", 1, 0, ovf_o[1][7:0], 255);

    // randomized traffic with varying pressure per phase
    wp = 50; pp = 50; sp = 50; rp = 50;
    for (int c = 0; c < 2500; c++) begin
      if (c % 250 == 0) begin
        wp = $urandom_range(5, 95); pp = $urandom_range(5, 95);
        sp = $urandom_range(5, 95); rp = $urandom_range(5, 95);
      end
      for (int i = 0; i < D; i++) begin
        wr_en[i] = ($urandom_range(0, 99) < wp);
        pop[i]   = ($urandom_range(0, 99) < pp);
        push[i]  = ($urandom_range(0, 99) < sp);
        rd_en[i] = ($urandom_range(0, 99) < rp);
      end
      wr_data = {$urandom(), $urandom()};
      D_push  = {$urandom(), $urandom()};
      cyc();
      if (c == 1300) async_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/drvr_fifo_bank.md
# drvr_fifo_bank

Parametrised bank of per-terminal FIFOs that sits between the testbench driver/monitor and the bus DUT terminals, one input FIFO and one output FIFO per terminal. Input FIFOs present first-word-fall-through data and `pndng` to the DUT's `pop`/`D_pop` ports. Output FIFOs capture `push`/`D_push` from the DUT for the monitor. Generalises the single-queue terminal model with configurable depth, selectable overflow policy, saturating overflow counters and sticky underflow flags.

## Interface
- `drvrs`, 4, number of terminals (channels), ≥1
- `pckg_sz`, 16, packet width in bits
- `depth`, 8, entries per FIFO, ≥2, need not be a power of two
- `ovf_mode`, 0, full-write policy: 0 = drop new word, 1 = overwrite oldest word
- `CW` (localparam), `$clog2(depth+1)`, count width

- `clk` in 1 system clock, all state on rising edge
- `reset` in 1 asynchronous, active-high; clears all state
- `wr_en` in drvrs driver write strobe, bit i → input FIFO i
- `wr_data` in drvrs*pckg_sz driver data, channel i at `[i*pckg_sz +: pckg_sz]`
- `pop` in drvrs DUT pop request per terminal
- `pndng` out drvrs input FIFO i non-empty
- `D_pop` out drvrs*pckg_sz head word of input FIFO i
- `push` in drvrs DUT push strobe per terminal
- `D_push` in drvrs*pckg_sz DUT push data
- `rd_en` in drvrs monitor read request per output FIFO
- `rd_data` out drvrs*pckg_sz registered read data
- `rd_valid` out drvrs read data valid, one cycle
- `in_count` out drvrs*CW occupancy of input FIFO i
- `out_count` out drvrs*CW occupancy of output FIFO i
- `ovf_cnt` out drvrs*8 saturating overflow count per channel (input + output combined)
- `udf_err` out drvrs sticky: pop on empty input or rd_en on empty output

## Operation
- Each FIFO: circular buffer, `head`/`tail` pointers wrap from `depth-1` to 0, `count` 0..depth.
- Input FIFO i: write on `wr_en[i]`, remove on `pop[i]`. Output FIFO i: write on `push[i]`, remove on `rd_en[i]`.
- `pndng[i]` = (in_count_i != 0); `D_pop` = mem[head] combinationally from registered state; value undefined-but-stable (drive 0) when empty.
- Write when not full: store at tail, tail++, count++.
- Write when full, no simultaneous remove:
  - `ovf_mode`=0: word discarded, state unchanged, `ovf_cnt[i]`++ (saturates at 255).
  - `ovf_mode`=1: word stored at tail, head++ and tail++, count stays `depth`, `ovf_cnt[i]`++.
- Write + remove same cycle when full: both succeed, count unchanged, no overflow increment.
- Write + remove same cycle when empty: write succeeds, remove ignored, `udf_err[i]` set, count → 1.
- Remove when empty (alone): ignored, `udf_err[i]` set, count stays 0.
- Input and output overflow in same cycle on one channel: `ovf_cnt[i]` += 2 (saturating).
- `udf_err` and `ovf_cnt` cleared only by `reset`.
- Channels fully independent; no arbitration between them.

## Timing
- Reset values: all counts 0, pointers 0, `pndng`=0, `D_pop`=0, `rd_data`=0, `rd_valid`=0, `ovf_cnt`=0, `udf_err`=0. Memory contents not reset.
- `reset` asserted mid-operation: all FIFOs empty immediately (asynchronous), in-flight `rd_valid` dropped.
- Write → `pndng`/`D_pop` visible: cycle after the write edge (1-cycle latency).
- `pop` at edge N: `D_pop` shows next word (or `pndng`=0) after edge N.
- `rd_en` at edge N on non-empty output FIFO: `rd_data`/`rd_valid` valid after edge N for one cycle; `rd_valid`=0 on empty read.
- Counts update on the same edge as the operation; `in_count`/`out_count` are registered.

## Test plan
- Reset then write 0x00A1,0x00A2,0x00A3 to ch0 → `pndng[0]`=1, `in_count0`=3, three `pop[0]` cycles yield D_pop 0x00A1,0x00A2,0x00A3, then `pndng[0]`=0.
- `ovf_mode`=0, write 9 words 0x0001..0x0009 to ch2 → `in_count2`=8, `ovf_cnt2`=1, pops return 0x0001..0x0008.
- `ovf_mode`=1, same stimulus → `in_count2`=8, `ovf_cnt2`=1, pops return 0x0002..0x0009.
- ch1 full, `wr_en`+`pop` same cycle with 0xBEEF → count stays 8, `ovf_cnt1`=0, 0xBEEF popped last; wrap-around verified over 20 iterations.
- `push[3]` 0x1234 then `rd_en[3]` → `rd_valid[3]`=1, `rd_data3`=0x1234; second `rd_en[3]` → `rd_valid[3]`=0, `udf_err[3]`=1.
- Fill ch0 with 5 words, assert `reset` between edges → `in_count0`=0, `pndng`=0, `udf_err`/`ovf_cnt` all 0 without waiting for clk.
